// File: rtl/perf_counter_bank.sv
// Bank of WIDTH-bit performance counters (cycles, retired instructions, generic events)
// with per-counter inhibit, sticky overflow and 32-bit CSR access through a hi-word shadow.
module perf_counter_bank #(
  parameter int WIDTH = 64,
  parameter int N_EVT = 4,
  localparam int NCNT  = N_EVT + 2,
  localparam int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             freeze,
  input  logic             instr_retired,
  input  logic [N_EVT-1:0] evt_in,
  input  logic [NCNT-1:0]  inhibit,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_hi,
  input  logic [31:0]      wr_data,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic             rd_hi,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  output logic [NCNT-1:0]  ovf,
  input  logic [NCNT-1:0]  ovf_clr
);

  localparam int HI_W = WIDTH - 32;

  function automatic logic [31:0] zext_hi(input logic [WIDTH-1:0] v);
    return 32'(v[WIDTH-1:32]);
  endfunction

  logic [WIDTH-1:0] cnt_r      [NCNT];
  logic [WIDTH-1:0] cnt_next_s [NCNT];
  logic [NCNT-1:0]  evt_s;
  logic [NCNT-1:0]  inc_s;
  logic [NCNT-1:0]  wrap_s;
  logic [NCNT-1:0]  ovf_r;
  logic [NCNT-1:0]  ovf_next_s;
  logic [WIDTH-1:0] rd_sel_s;
  logic             rd_hit_s;
  logic [31:0]      shadow_r;
  logic [31:0]      rd_data_r;
  logic             rd_valid_r;

  // Per-counter event source and qualified increment enable
  always_comb begin
    evt_s = {evt_in, instr_retired, 1'b1};
    inc_s = evt_s & ~inhibit & {NCNT{~freeze}};
  end

  // Next counter values: a CSR write replaces the increment for that counter
  always_comb begin
    wrap_s = '0;
    for (int i = 0; i < NCNT; i++) begin
      cnt_next_s[i] = cnt_r[i];
      if (wr_en && (wr_idx == IDX_W'(i))) begin
        if (wr_hi) begin
          cnt_next_s[i] = {wr_data[HI_W-1:0], cnt_r[i][31:0]};
        end else begin
          cnt_next_s[i] = {cnt_r[i][WIDTH-1:32], wr_data};
        end
      end else if (inc_s[i]) begin
        cnt_next_s[i] = cnt_r[i] + {{(WIDTH-1){1'b0}}, 1'b1};
        wrap_s[i]     = &cnt_r[i];
      end else begin
        cnt_next_s[i] = cnt_r[i];
      end
    end
    ovf_next_s = (ovf_r & ~ovf_clr) | wrap_s;
  end

  // Read-side counter select; out-of-range indices select nothing and yield zero
  always_comb begin
    rd_sel_s = '0;
    rd_hit_s = 1'b0;
    for (int i = 0; i < NCNT; i++) begin
      rd_sel_s = rd_sel_s | (cnt_r[i] & {WIDTH{rd_idx == IDX_W'(i)}});
      rd_hit_s = rd_hit_s | (rd_idx == IDX_W'(i));
    end
  end

  // Counter array and sticky overflow state
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCNT; i++) begin
        cnt_r[i] <= '0;
      end
      ovf_r <= '0;
    end else begin
      for (int i = 0; i < NCNT; i++) begin
        cnt_r[i] <= cnt_next_s[i];
      end
      ovf_r <= ovf_next_s;
    end
  end

  // Registered read port; a lo read snapshots the hi half so a following hi read is coherent
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_r  <= 32'd0;
      rd_valid_r <= 1'b0;
      shadow_r   <= 32'd0;
    end else begin
      rd_valid_r <= rd_en;
      if (rd_en) begin
        if (rd_hi) begin
          rd_data_r <= shadow_r;
        end else if (rd_hit_s) begin
          rd_data_r <= rd_sel_s[31:0];
          shadow_r  <= zext_hi(rd_sel_s);
        end else begin
          rd_data_r <= 32'd0;
          shadow_r  <= 32'd0;
        end
      end
    end
  end

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign ovf      = ovf_r;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed self-checking bench for perf_counter_bank (WIDTH=64, N_EVT=4).
module tb_perf_counter_bank;

  localparam int WIDTH = 64;
  localparam int N_EVT = 4;
  localparam int NCNT  = N_EVT + 2;

  logic             clk;
  logic             reset;
  logic             freeze;
  logic             instr_retired;
  logic [N_EVT-1:0] evt_in;
  logic [NCNT-1:0]  inhibit;
  logic             wr_en;
  logic [3:0]       wr_idx;
  logic             wr_hi;
  logic [31:0]      wr_data;
  logic             rd_en;
  logic [3:0]       rd_idx;
  logic             rd_hi;
  logic [31:0]      rd_data;
  logic             rd_valid;
  logic [NCNT-1:0]  ovf;
  logic [NCNT-1:0]  ovf_clr;

  int n_cmp = 0;
  int n_err = 0;

  perf_counter_bank #(.WIDTH(WIDTH), .N_EVT(N_EVT)) dut (
    .clk(clk), .reset(reset), .freeze(freeze), .instr_retired(instr_retired),
    .evt_in(evt_in), .inhibit(inhibit),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_hi(wr_hi), .wr_data(wr_data),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_hi(rd_hi),
    .rd_data(rd_data), .rd_valid(rd_valid), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_wr(input logic [3:0] idx, input logic hi, input logic [31:0] d);
    wr_en = 1'b1; wr_idx = idx; wr_hi = hi; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_rd(input logic [3:0] idx, input logic hi, output logic [31:0] d);
    rd_en = 1'b1; rd_idx = idx; rd_hi = hi;
    step();
    rd_en = 1'b0;
    check_eq("rd_valid", 64'(rd_valid), 64'h1);
    d = rd_data;
  endtask

  logic [31:0] d;

  initial begin
    reset = 1'b1; freeze = 1'b0; instr_retired = 1'b0; evt_in = '0; inhibit = '0;
    wr_en = 1'b0; wr_idx = 4'd0; wr_hi = 1'b0; wr_data = 32'd0;
    rd_en = 1'b0; rd_idx = 4'd0; rd_hi = 1'b0; ovf_clr = '0;
    step(); step(); step();
    check_eq("reset rd_data", 64'(rd_data), 64'h0);
    check_eq("reset rd_valid", 64'(rd_valid), 64'h0);
    check_eq("reset ovf", 64'(ovf), 64'h0);

    // 1: ten idle cycles after reset release, read issued on cycle 10
    reset = 1'b0;
    for (int c = 0; c < 10; c++) step();
    do_rd(4'd0, 1'b0, d); check_eq("t1 cnt0 lo", 64'(d), 64'd10);
    do_rd(4'd0, 1'b1, d); check_eq("t1 cnt0 hi", 64'(d), 64'd0);
    for (int i = 1; i < NCNT; i++) begin
      do_rd(4'(i), 1'b0, d); check_eq("t1 cntN lo", 64'(d), 64'd0);
    end

    // 2: wrap of counter 2, sticky ovf, clear, set-wins-over-clear
    do_wr(4'd2, 1'b0, 32'hFFFF_FFFF);
    do_wr(4'd2, 1'b1, 32'hFFFF_FFFF);
    evt_in = 4'b0001; step(); evt_in = '0;
    check_eq("t2 ovf set", 64'(ovf), 64'h04);
    do_rd(4'd2, 1'b0, d); check_eq("t2 cnt2 lo", 64'(d), 64'h0);
    do_rd(4'd2, 1'b1, d); check_eq("t2 cnt2 hi", 64'(d), 64'h0);
    check_eq("t2 ovf sticky", 64'(ovf), 64'h04);
    do_wr(4'd2, 1'b0, 32'hFFFF_FFFF);
    do_wr(4'd2, 1'b1, 32'hFFFF_FFFF);
    check_eq("t2 ovf after write", 64'(ovf), 64'h04);
    evt_in = 4'b0001; ovf_clr = 6'b000100; step(); evt_in = '0; ovf_clr = '0;
    check_eq("t2 set beats clear", 64'(ovf), 64'h04);
    ovf_clr = 6'b000100; step(); ovf_clr = '0;
    check_eq("t2 ovf cleared", 64'(ovf), 64'h0);

    // 3: hi-word shadow coherency across a lo->hi carry
    do_wr(4'd0, 1'b1, 32'h0);
    do_wr(4'd0, 1'b0, 32'hFFFF_FFFE);
    step();
    do_rd(4'd0, 1'b0, d); check_eq("t3 lo", 64'(d), 64'hFFFF_FFFF);
    do_rd(4'd0, 1'b1, d); check_eq("t3 hi shadow", 64'(d), 64'h0);
    do_rd(4'd0, 1'b0, d); check_eq("t3 lo after carry", 64'(d), 64'h1);
    do_rd(4'd0, 1'b1, d); check_eq("t3 hi after carry", 64'(d), 64'h1);
    step();
    check_eq("t3 rd_valid idle", 64'(rd_valid), 64'h0);
    check_eq("t3 rd_data hold", 64'(rd_data), 64'h1);

    // 4: write beats increment; same-cycle read sees the old value
    instr_retired = 1'b1; step(); step(); step(); instr_retired = 1'b0;
    instr_retired = 1'b1;
    wr_en = 1'b1; wr_idx = 4'd1; wr_hi = 1'b0; wr_data = 32'h100;
    rd_en = 1'b1; rd_idx = 4'd1; rd_hi = 1'b0;
    step();
    instr_retired = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    check_eq("t4 rd_valid", 64'(rd_valid), 64'h1);
    check_eq("t4 old value", 64'(rd_data), 64'h3);
    do_rd(4'd1, 1'b0, d); check_eq("t4 written", 64'(d), 64'h100);

    // 5: inhibit and freeze
    inhibit = 6'b001000;
    for (int c = 0; c < 20; c++) begin
      evt_in = (c % 2 == 0) ? 4'b0110 : 4'b0000;
      step();
    end
    evt_in = '0; inhibit = '0;
    do_rd(4'd3, 1'b0, d); check_eq("t5 inhibited", 64'(d), 64'h0);
    do_rd(4'd4, 1'b0, d); check_eq("t5 cnt4", 64'(d), 64'd10);
    do_wr(4'd0, 1'b1, 32'h0);
    do_wr(4'd0, 1'b0, 32'h0);
    freeze = 1'b1; instr_retired = 1'b1;
    wr_en = 1'b1; wr_idx = 4'd5; wr_hi = 1'b0; wr_data = 32'hABCD;
    step();
    wr_en = 1'b0;
    for (int c = 0; c < 4; c++) step();
    freeze = 1'b0; instr_retired = 1'b0;
    for (int c = 0; c < 4; c++) step();
    do_rd(4'd0, 1'b0, d); check_eq("t5 freeze cnt0", 64'(d), 64'd4);
    do_rd(4'd1, 1'b0, d); check_eq("t5 freeze cnt1", 64'(d), 64'h100);
    do_rd(4'd5, 1'b0, d); check_eq("t5 write in freeze", 64'(d), 64'hABCD);

    // 6: out-of-range accesses and reset killing a pending read
    do_wr(4'd5, 1'b1, 32'h77);
    do_wr(4'd15, 1'b0, 32'h55);
    do_wr(4'd15, 1'b1, 32'h55);
    do_rd(4'd1, 1'b0, d); check_eq("t6 cnt1", 64'(d), 64'h100);
    do_rd(4'd2, 1'b0, d); check_eq("t6 cnt2", 64'(d), 64'h0);
    do_rd(4'd3, 1'b0, d); check_eq("t6 cnt3", 64'(d), 64'h0);
    do_rd(4'd4, 1'b0, d); check_eq("t6 cnt4", 64'(d), 64'd10);
    do_rd(4'd5, 1'b0, d); check_eq("t6 cnt5 lo", 64'(d), 64'hABCD);
    do_rd(4'd5, 1'b1, d); check_eq("t6 cnt5 hi", 64'(d), 64'h77);
    do_rd(4'd15, 1'b0, d); check_eq("t6 oor lo", 64'(d), 64'h0);
    do_rd(4'd15, 1'b1, d); check_eq("t6 oor shadow", 64'(d), 64'h0);
    do_rd(4'd5, 1'b0, d); check_eq("t6 cnt5 reread", 64'(d), 64'hABCD);
    rd_en = 1'b1; rd_idx = 4'd5; rd_hi = 1'b0; reset = 1'b1;
    step();
    rd_en = 1'b0; reset = 1'b0;
    check_eq("t6 reset rd_valid", 64'(rd_valid), 64'h0);
    check_eq("t6 reset rd_data", 64'(rd_data), 64'h0);
    check_eq("t6 reset ovf", 64'(ovf), 64'h0);
    do_rd(4'd4, 1'b0, d); check_eq("t6 cnt4 after reset", 64'(d), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
Parametrised successor to the single free-running cycle counter in the core top level. It holds a bank of WIDTH-bit counters:
- counter 0: cycles
- counter 1: retired instructions
- counters 2..N_EVT+1: generic event inputs

Each counter has a per-counter inhibit bit, sticky overflow and CSR-style 32-bit read/write access. Reads use a hi-word shadow so 64-bit values are coherent. The bank sits beside the datapath, and the CSR unit drives its access ports.

Parameters:
WIDTH, 64, counter width in bits; legal range 33..64. The hi half is WIDTH-32 bits and is zero-extended on read.
N_EVT, 4, number of generic event counters; legal range 1..13.
NCNT (localparam), N_EVT+2, total number of counters.
IDX_W (localparam), 4, counter index width; fixed at 4, so indices 0..15.

Ports:
clk  in  1  system clock; all state changes on its rising edge
reset  in  1  synchronous, active-high reset
freeze  in  1  global halt; while 1, no counter increments (writes still apply)
instr_retired  in  1  one pulse per retired instruction; increments counter 1
evt_in  in  N_EVT  event pulses; bit k increments counter k+2
inhibit  in  NCNT  per-counter inhibit; bit i=1 stops counter i from incrementing
wr_en  in  1  write strobe
wr_idx  in  IDX_W  counter index for the write
wr_hi  in  1  0 = write bits [31:0]; 1 = write bits [WIDTH-1:32]
wr_data  in  32  write data; upper bits are ignored for the hi half
rd_en  in  1  read strobe
rd_idx  in  IDX_W  counter index for the read
rd_hi  in  1  0 = read lo word and capture hi into shadow; 1 = return shadow
rd_data  out  32  read data, registered
rd_valid  out  1  pulses 1 the cycle after rd_en
ovf  out  NCNT  sticky overflow flags, one per counter
ovf_clr  in  NCNT  write-1-to-clear mask for ovf

Behaviour:
- Reset (synchronous, priority over everything): all counters 0, ovf 0, shadow 0, rd_data 0, rd_valid 0. Asserting reset mid-operation discards any pending read; rd_valid is 0 in the following cycle.
- Increment condition for counter i in a cycle: not freeze, inhibit[i]=0, and its event is 1.
  - Counter 0's event is a constant 1.
  - Counter 1's event is instr_retired.
  - Counter k+2's event is evt_in[k].
  - At most +1 per cycle.
- Wrap-around: if counter i increments from 2^WIDTH-1, it becomes 0 and ovf[i] is set in the same edge.
- ovf update per cycle: ovf_next = (ovf & ~ovf_clr) | wrap_set. Set wins over clear in the same cycle.
- Write: on wr_en with wr_idx < NCNT, the selected half is loaded from wr_data and the other half is preserved.
  - The write takes priority over the increment for that counter in that cycle: the new value is exactly the written half merged with the old other half, with no +1.
  - A write never sets ovf.
  - wr_idx >= NCNT: write ignored.
- Read, 1-cycle latency: on rd_en, at the next edge rd_valid=1 and rd_data takes the value below. rd_valid is 0 in any cycle without a read on the prior edge. rd_data holds its last value when no read occurs.
  - rd_hi=0, idx valid: rd_data = counter[rd_idx][31:0] sampled before this edge's update. The shadow is loaded with the zero-extended counter[rd_idx][WIDTH-1:32] from the same sample.
  - rd_hi=1: rd_data = shadow, regardless of rd_idx. The shadow is unchanged.
  - rd_hi=0 with rd_idx >= NCNT: rd_data = 0 and shadow = 0.
- Simultaneous read and write of the same counter: the read returns the pre-write value. A subsequent lo read sees the written value.
- Simultaneous read and increment: the read returns the pre-increment value.
- freeze does not block reads, writes, ovf_clr or the shadow.
- Counter state is a NCNT x WIDTH register array; there is no memory macro.

Test Plan:
1. Reset, then 10 idle cycles with inhibit=0 → lo read of counter 0 returns 10 ± the read-issue offset (exactly 10 when rd_en is issued on cycle 10 after reset release); counters 1..NCNT-1 read 0.
2. Write counter 2: lo=0xFFFFFFFF, hi=0xFFFFFFFF (WIDTH=64), then one evt_in[0] pulse → counter 2 reads 0/0; ovf[2]=1 and stays 1. Pulse ovf_clr[2] → ovf[2]=0. Wrap coinciding with ovf_clr[2] → ovf[2]=1.
3. Coherency: write counter 0 to 0x00000000_FFFFFFFE, read lo then hi on the next cycles while it counts → lo=0xFFFFFFFF (or 0xFFFFFFFE per issue cycle), hi=0x00000000 taken from the shadow, even though the live hi has become 1.
4. Priority: wr_en to counter 1 lo with 0x100 in the same cycle as instr_retired=1 → counter 1 lo=0x100 (not 0x101). A read of counter 1 in that same cycle returns the old value.
5. inhibit[3]=1 and freeze pulses: evt_in[1] toggled 20 cycles → counter 3 unchanged. Freeze for 5 cycles → counter 0 advances exactly 5 less than elapsed cycles. Writes during freeze take effect.
6. Out-of-range: wr_idx=15 write → no counter changes. rd_idx=15, rd_hi=0 → rd_data=0, then rd_hi=1 → 0. Assert reset between rd_en and its response → rd_valid=0, rd_data=0.
